// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: sequential ROM fetch into a PC-tagged FIFO, redirect flush.
// Optional PREFETCH_STATS_EN adds saturating redirect/dropped-instruction counters.
module inst_prefetch #(
  parameter int PC_W   = 8,
  parameter int INST_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic [PC_W-1:0]          start_addr,
  output logic                     rom_en,
  output logic [PC_W-1:0]          rom_addr,
  input  logic [INST_W-1:0]        rom_data,
  output logic                     inst_valid,
  output logic [INST_W-1:0]        inst,
  output logic [PC_W-1:0]          inst_pc,
  input  logic                     inst_take,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_target,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [7:0]               stat_redirects,
  output logic [7:0]               stat_dropped
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [PC_W-1:0]   r_fetch_pc;
  logic              r_inflight;
  logic [PC_W-1:0]   r_inflight_pc;
  logic [INST_W-1:0] r_mem_inst [DEPTH];
  logic [PC_W-1:0]   r_mem_pc   [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              w_push;
  logic              w_pop;
  logic [CW:0]       w_occ;

  // Credit counts queued plus in-flight; a same-cycle pop is not credited.
  assign w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign rom_en = ~init & ~redirect & (w_occ < (CW+1)'(DEPTH));
  assign w_push = r_inflight & ~redirect & ~init;
  assign w_pop  = inst_take & (r_count != '0) & ~redirect & ~init;

  assign rom_addr   = r_fetch_pc;
  assign inst_valid = (r_count != '0);
  assign inst       = r_mem_inst[r_rd_ptr];
  assign inst_pc    = r_mem_pc[r_rd_ptr];
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (init) begin
      r_fetch_pc <= start_addr;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      // Data returning this cycle belongs to the old stream and is dropped.
      r_fetch_pc <= redirect_target;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= rom_en;
      if (rom_en) begin
        r_fetch_pc    <= r_fetch_pc + PC_W'(1);
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= rom_data;
      r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [8:0] w_drop_sum;
  assign w_drop_sum = {1'b0, stat_dropped} + 9'(w_occ);

  always_ff @(posedge clk) begin
    if (init) begin
      stat_redirects <= '0;
      stat_dropped   <= '0;
    end else if (redirect) begin
      if (stat_redirects != 8'hFF) stat_redirects <= stat_redirects + 8'd1;
      stat_dropped <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end
`endif
endmodule

// File: tb/tb_inst_prefetch.sv
// Directed vector bench for inst_prefetch with a registered ROM model (ROM[a] = a + 0x100).
module tb_inst_prefetch;
  logic       clk = 1'b0;
  logic       init, inst_take, redirect;
  logic [7:0] start_addr, redirect_target;
  logic       rom_en, inst_valid;
  logic [7:0] rom_addr, inst_pc;
  logic [8:0] rom_data, inst;
  logic [2:0] fifo_count;
`ifdef PREFETCH_STATS_EN
  logic [7:0] stat_redirects, stat_dropped;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= {1'b1, rom_addr};

  inst_prefetch dut (
    .clk(clk), .init(init), .start_addr(start_addr),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_take(inst_take), .redirect(redirect), .redirect_target(redirect_target),
    .fifo_count(fifo_count)
`ifdef PREFETCH_STATS_EN
    , .stat_redirects(stat_redirects), .stat_dropped(stat_dropped)
`endif
  );

  typedef struct {
    logic       init;  logic [7:0] sa;
    logic       take;  logic       redir; logic [7:0] tgt;
    logic       en;    logic [7:0] addr;
    logic       vld;   logic [7:0] pc;    logic [2:0] cnt;
    logic       st;    logic [7:0] sr;    logic [7:0] sd;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(int ini, int sa, int tk, int rd, int tg,
                              int en, int ad, int vl, int pc, int cn,
                              int st = 0, int sr = 0, int sd = 0);
    vec_t v;
    v.init = ini[0]; v.sa = 8'(sa); v.take = tk[0]; v.redir = rd[0]; v.tgt = 8'(tg);
    v.en = en[0]; v.addr = 8'(ad); v.vld = vl[0]; v.pc = 8'(pc); v.cnt = 3'(cn);
    v.st = st[0]; v.sr = 8'(sr); v.sd = 8'(sd);
    return v;
  endfunction

  task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", nm, row, act, exp);
    end
  endtask

  initial begin
    //            init sa   tk rd tgt   en addr  vld pc   cnt  st sr sd
    tv.push_back(mk(1, 'h10, 0, 0, 0,    0, 0,    0, 0,    0));  // 0 reset
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h10, 0, 0,    0));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h11, 0, 0,    0));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h12, 1, 'h10, 1));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h13, 1, 'h10, 2));
    tv.push_back(mk(0, 0,    0, 0, 0,    0, 0,    1, 'h10, 3));  // 5 credit exhausted
    tv.push_back(mk(0, 0,    0, 0, 0,    0, 0,    1, 'h10, 4));
    tv.push_back(mk(0, 0,    0, 0, 0,    0, 0,    1, 'h10, 4));
    tv.push_back(mk(0, 0,    1, 0, 0,    0, 0,    1, 'h10, 4));  // 8 drain/stream
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h14, 1, 'h11, 3));
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h15, 1, 'h12, 2));
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h16, 1, 'h13, 2));
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h17, 1, 'h14, 2));
    tv.push_back(mk(1, 'h20, 0, 0, 0,    0, 0,    1, 'h15, 2));  // 13 re-init
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h20, 0, 0,    0));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h21, 0, 0,    0));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h22, 1, 'h20, 1));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h23, 1, 'h20, 2));
    tv.push_back(mk(0, 0,    1, 1, 'h40, 0, 0,    1, 'h20, 3, 1, 0, 0));  // 18 redirect+take
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h40, 0, 0,    0, 1, 1, 4));
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h41, 0, 0,    0));
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h42, 1, 'h40, 1));
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h43, 1, 'h41, 1));
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h44, 1, 'h42, 1));
    tv.push_back(mk(0, 0,    0, 1, 'h60, 0, 0,    1, 'h43, 1));  // 24 back-to-back redirects
    tv.push_back(mk(0, 0,    0, 1, 'h80, 0, 0,    0, 0,    0));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h80, 0, 0,    0, 1, 3, 6));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h81, 0, 0,    0));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h82, 1, 'h80, 1));
    tv.push_back(mk(1, 'hFF, 0, 1, 'h50, 0, 0,    1, 'h80, 2));  // 29 init beats redirect
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'hFF, 0, 0,    0, 1, 0, 0));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h00, 0, 0,    0));  // PC wrap
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h01, 1, 'hFF, 1));
    tv.push_back(mk(0, 0,    1, 0, 0,    1, 'h02, 1, 'h00, 1));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h03, 1, 'h01, 1));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h04, 1, 'h01, 2));
    tv.push_back(mk(1, 'h30, 1, 0, 0,    0, 0,    1, 'h01, 3));  // 36 mid-run init
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h30, 0, 0,    0));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h31, 0, 0,    0));
    tv.push_back(mk(0, 0,    0, 0, 0,    1, 'h32, 1, 'h30, 1));

    init = 1'b1; start_addr = 8'h00; inst_take = 1'b0;
    redirect = 1'b0; redirect_target = 8'h00;
    @(posedge clk); #1;

    foreach (tv[i]) begin
      init = tv[i].init; start_addr = tv[i].sa; inst_take = tv[i].take;
      redirect = tv[i].redir; redirect_target = tv[i].tgt;
      #1;
      chk("rom_en", i, 32'(rom_en), 32'(tv[i].en));
      if (tv[i].en) chk("rom_addr", i, 32'(rom_addr), 32'(tv[i].addr));
      chk("inst_valid", i, 32'(inst_valid), 32'(tv[i].vld));
      if (tv[i].vld) begin
        chk("inst_pc", i, 32'(inst_pc), 32'(tv[i].pc));
        chk("inst", i, 32'(inst), 32'({1'b1, tv[i].pc}));
      end
      chk("fifo_count", i, 32'(fifo_count), 32'(tv[i].cnt));
`ifdef PREFETCH_STATS_EN
      if (tv[i].st) begin
        chk("stat_redirects", i, 32'(stat_redirects), 32'(tv[i].sr));
        chk("stat_dropped", i, 32'(stat_dropped), 32'(tv[i].sd));
      end
`endif
      @(posedge clk); #1;
    end

    // Fresh start with the decoder always ready: 2-cycle fill then gap-free stream.
    begin
      int n;
      init = 1'b1; start_addr = 8'h10; inst_take = 1'b0; redirect = 1'b0;
      @(posedge clk); #1;
      init = 1'b0; inst_take = 1'b1;
      n = 0;
      while (!inst_valid && n < 8) begin
        @(posedge clk); #1;
        n++;
      end
      chk("fill_latency", 100, 32'(n), 32'd2);
      for (int k = 0; k < 8; k++) begin
        chk("stream_valid", 100 + k, 32'(inst_valid), 32'd1);
        chk("stream_pc", 100 + k, 32'(inst_pc), 32'(8'h10 + 8'(k)));
        chk("stream_count", 100 + k, 32'(fifo_count), 32'd1);
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
